// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage.
//   fetch_state_t - sequencing FSM states
//   HALT_INSTR    - all-ones instruction that stops execution
//   BRANCH_LUT    - assembler-generated table of absolute branch targets
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } fetch_state_t;

   localparam int unsigned LUT_PC_W  = 10;
   localparam int unsigned LUT_DEPTH = 32;

   localparam logic [8:0] HALT_INSTR = 9'h1FF;

   // Indexed by instr[4:0]; edit only this table when the program changes.
   localparam logic [LUT_PC_W-1:0] BRANCH_LUT [LUT_DEPTH] = '{
      10'h100, 10'h107, 10'h10E, 10'h040, 10'h11C, 10'h3FF, 10'h12A, 10'h131,
      10'h138, 10'h13F, 10'h146, 10'h14D, 10'h154, 10'h15B, 10'h162, 10'h169,
      10'h170, 10'h177, 10'h17E, 10'h185, 10'h18C, 10'h193, 10'h19A, 10'h1A1,
      10'h1A8, 10'h1AF, 10'h1B6, 10'h1BD, 10'h1C4, 10'h1CB, 10'h1D2, 10'h155
   };

endpackage

// File: rtl/branch_lut.sv
// branch_lut: combinational branch-target lookup into BRANCH_LUT.
//   idx_i    - table index (low instruction bits)
//   target_o - absolute PC target
module branch_lut
   import fetch_pkg::*;
#(
   parameter int unsigned PC_W   = 10,
   parameter int unsigned LUT_AW = 5
) (
   input  logic [LUT_AW-1:0] idx_i,
   output logic [PC_W-1:0]   target_o
);

   assign target_o = PC_W'(BRANCH_LUT[idx_i]);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter and fetch sequencing with start/done handshake.
//   clk, reset  - clock, synchronous active-high reset
//   start       - level-sensitive launch request
//   instr       - instruction at prog_ctr
//   branch      - taken-branch decision for instr
//   prog_ctr    - registered PC / instruction-memory address
//   running     - high in RUN (write enable gate)
//   done        - high in DONE
//   cycle_count - saturating count of RUN cycles since last launch
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned PC_W   = 10,
   parameter int unsigned IW     = 9,
   parameter int unsigned LUT_AW = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [IW-1:0]    instr,
   input  logic             branch,
   output logic [PC_W-1:0]  prog_ctr,
   output logic             running,
   output logic             done,
   output logic [CNT_W-1:0] cycle_count
);

   fetch_state_t     state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             running_q, done_q;
   logic [PC_W-1:0]  lut_target;
   logic             halt;

   branch_lut #(
      .PC_W   (PC_W),
      .LUT_AW (LUT_AW)
   ) u_branch_lut (
      .idx_i    (instr[LUT_AW-1:0]),
      .target_o (lut_target)
   );

   assign halt = &instr;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = ARMED;
               pc_d    = '0;
               cnt_d   = '0;
            end
         end
         ARMED: begin
            pc_d  = '0;
            cnt_d = '0;
            if (!start) state_d = RUN;
         end
         RUN: begin
            if (start) begin
               // Restart: nothing completes on this edge.
               state_d = ARMED;
               pc_d    = '0;
               cnt_d   = '0;
            end else begin
               if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
               // Halt beats branch; PC stays on the halt address.
               if (halt)        state_d = DONE;
               else if (branch) pc_d    = lut_target;
               else             pc_d    = pc_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         cnt_q     <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         cnt_q     <= cnt_d;
         running_q <= (state_d == RUN);
         done_q    <= (state_d == DONE);
      end
   end

   assign prog_ctr    = pc_q;
   assign running     = running_q;
   assign done        = done_q;
   assign cycle_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start, branch;
   logic [8:0]  instr;
   logic [9:0]  prog_ctr, prog_ctr4;
   logic        running, done, running4, done4;
   logic [15:0] cycle_count;
   logic [3:0]  cycle_count4;

   always #5 clk = ~clk;

   fetch_unit u_dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .instr       (instr),
      .branch      (branch),
      .prog_ctr    (prog_ctr),
      .running     (running),
      .done        (done),
      .cycle_count (cycle_count)
   );

   fetch_unit #(.CNT_W(4)) u_dut4 (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .instr       (instr),
      .branch      (branch),
      .prog_ctr    (prog_ctr4),
      .running     (running4),
      .done        (done4),
      .cycle_count (cycle_count4)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
   endtask

   // Reference model: mode 0 idle, 1 armed, 2 run, 3 done; unbounded count.
   localparam int MIdle = 0, MArmed = 1, MRun = 2, MDone = 3;
   int m_st  = MIdle;
   int m_pc  = 0;
   int m_cnt = 0;

   task automatic model_step(input bit rst, input bit s, input logic [8:0] in, input bit br);
      logic [4:0] idx;
      idx = in[4:0];
      if (rst) begin
         m_st = MIdle; m_pc = 0; m_cnt = 0;
      end else if (m_st == MArmed) begin
         if (!s) m_st = MRun;
      end else if (s) begin
         m_st = MArmed; m_pc = 0; m_cnt = 0;
      end else if (m_st == MRun) begin
         m_cnt++;
         if (in == HALT_INSTR) m_st = MDone;
         else if (br)          m_pc = int'(BRANCH_LUT[idx]);
         else                  m_pc = (m_pc + 1) % 1024;
      end
   endtask

   task automatic compare_all();
      check_eq("pc", 32'(prog_ctr), 32'(m_pc));
      check_eq("running", 32'(running), 32'(m_st == MRun));
      check_eq("done", 32'(done), 32'(m_st == MDone));
      check_eq("count16", 32'(cycle_count), 32'((m_cnt > 65535) ? 65535 : m_cnt));
      check_eq("count4", 32'(cycle_count4), 32'((m_cnt > 15) ? 15 : m_cnt));
      check_eq("pc_w4", 32'(prog_ctr4), 32'(m_pc));
   endtask

   // Drive one cycle's inputs, clock, update model, sample 1 unit after the edge.
   task automatic cycle(input bit rst, input bit s, input logic [8:0] in, input bit br);
      reset = rst; start = s; instr = in; branch = br;
      @(posedge clk);
      model_step(rst, s, in, br);
      #1;
      compare_all();
   endtask

   task automatic launch();
      cycle(1'b0, 1'b1, 9'h000, 1'b0);
      cycle(1'b0, 1'b0, 9'h000, 1'b0);
   endtask

   logic [8:0] imem [1024];

   initial begin
      reset = 1'b1; start = 1'b1; branch = 1'b1; instr = 9'h1FF;

      // Reset dominates start/branch/halt
      cycle(1'b1, 1'b1, 9'h1FF, 1'b1);
      cycle(1'b1, 1'b1, 9'h1FF, 1'b1);
      check_eq("rst_pc", 32'(prog_ctr), 32'd0);
      check_eq("rst_cnt", 32'(cycle_count), 32'd0);
      cycle(1'b0, 1'b0, 9'h000, 1'b1);  // IDLE ignores branch

      // Sequential run ending in halt
      launch();
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 9'h000, 1'b0);
      cycle(1'b0, 1'b0, 9'h1FF, 1'b0);
      check_eq("seq_pc", 32'(prog_ctr), 32'd5);
      check_eq("seq_done", 32'(done), 32'd1);
      check_eq("seq_cnt", 32'(cycle_count), 32'd6);
      cycle(1'b0, 1'b0, 9'h1FF, 1'b1);  // DONE holds

      // Branch taken / not taken at PC=2
      launch();
      cycle(1'b0, 1'b0, 9'h000, 1'b0);
      cycle(1'b0, 1'b0, 9'h000, 1'b0);
      cycle(1'b0, 1'b0, 9'h003, 1'b1);
      check_eq("br_taken", 32'(prog_ctr), 32'h040);
      launch();
      cycle(1'b0, 1'b0, 9'h000, 1'b0);
      cycle(1'b0, 1'b0, 9'h000, 1'b0);
      cycle(1'b0, 1'b0, 9'h003, 1'b0);
      check_eq("br_not_taken", 32'(prog_ctr), 32'd3);

      // Halt wins over branch
      cycle(1'b0, 1'b0, 9'h1FF, 1'b1);
      check_eq("halt_br_pc", 32'(prog_ctr), 32'd3);
      check_eq("halt_br_done", 32'(done), 32'd1);

      // Restart mid-run at PC=7
      launch();
      for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 9'h000, 1'b0);
      cycle(1'b0, 1'b1, 9'h000, 1'b1);
      check_eq("restart_pc", 32'(prog_ctr), 32'd0);
      check_eq("restart_cnt", 32'(cycle_count), 32'd0);
      check_eq("restart_run", 32'(running), 32'd0);
      cycle(1'b0, 1'b0, 9'h000, 1'b0);
      cycle(1'b0, 1'b0, 9'h000, 1'b0);
      check_eq("resume_pc", 32'(prog_ctr), 32'd1);
      cycle(1'b0, 1'b0, 9'h1FF, 1'b0);
      launch();
      check_eq("relaunch_pc", 32'(prog_ctr), 32'd0);
      check_eq("relaunch_run", 32'(running), 32'd1);

      // Wrap at 1023 and 4-bit count saturation
      cycle(1'b0, 1'b0, 9'h005, 1'b1);
      check_eq("to_max_pc", 32'(prog_ctr), 32'h3FF);
      cycle(1'b0, 1'b0, 9'h000, 1'b0);
      check_eq("wrap_pc", 32'(prog_ctr), 32'd0);
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 9'h000, 1'b0);
      check_eq("sat4", 32'(cycle_count4), 32'd15);
      check_eq("cnt16_22", 32'(cycle_count), 32'd22);

      // start held: parked in ARMED
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 9'h003, 1'b1);
      check_eq("armed_pc", 32'(prog_ctr), 32'd0);

      // Randomized program execution
      for (int i = 0; i < 1024; i++)
         imem[i] = ($urandom_range(0, 99) < 4) ? 9'h1FF : 9'($urandom_range(0, 510));
      for (int i = 0; i < 3000; i++) begin
         bit r, s, b;
         r = ($urandom_range(0, 199) == 0);
         s = ($urandom_range(0, 99) < 3);
         b = ($urandom_range(0, 3) == 0);
         cycle(r, s, imem[m_pc], b);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch-sequencing stage that sits directly upstream of the control decoder. It holds the PC and drives the instruction-memory address. It applies the decoder's `branch` decision through a branch-target lookup table. It runs the start/done handshake with the testbench or top level. It also counts executed cycles for performance reporting.

## Interface
- `PC_W`, default 10: PC / instruction-memory address width.
- `IW`, default 9: instruction width.
- `LUT_AW`, default 5: branch LUT index width; index = `instr[LUT_AW-1:0]`.
- `CNT_W`, default 16: cycle-counter width.
- `clk`  in  1: single clock. All state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: program launch request, level-sensitive.
- `instr`  in  IW: instruction currently read from instruction memory at `prog_ctr`.
- `branch`  in  1: taken-branch decision from the control decoder for the current `instr`.
- `prog_ctr`  out  PC_W: registered PC, feeds instruction-memory address.
- `running`  out  1: high in RUN only. Gates register-file and memory writes at top level.
- `done`  out  1: high in DONE only.
- `cycle_count`  out  CNT_W: number of RUN cycles since the last launch.

## Operation
- States:
  - IDLE: after reset.
  - ARMED: start held.
  - RUN: executing.
  - DONE: halted.
- Transitions:
  - IDLE: `start`=1 → ARMED.
  - ARMED: `start`=0 → RUN.
  - RUN: `start`=1 → ARMED (restart). Otherwise halt detected → DONE.
  - DONE: `start`=1 → ARMED.
- Halt instruction: `instr` == all ones (`9'h1FF`). Halt is detected only in RUN.
- PC update:
  - ARMED: PC ← 0.
  - RUN, not halting: PC ← `branch` ? `lut[instr[LUT_AW-1:0]]` : PC+1.
  - RUN with halt: PC holds on the HALT address.
  - IDLE and DONE: PC holds.
- `branch` is ignored outside RUN.
- If halt and `branch` are both true in the same cycle, halt wins and PC holds.
- PC+1 at 2^PC_W−1 wraps to 0. No flag is raised.
- `cycle_count`:
  - Cleared on entry to ARMED.
  - Increments once per RUN cycle, including the HALT cycle.
  - Saturates at 2^CNT_W−1.
  - Holds in DONE and IDLE.
- LUT targets are absolute PC values, PC_W bits wide. Contents are fixed at elaboration.

## Timing
- Reset values: state IDLE, `prog_ctr`=0, `running`=0, `done`=0, `cycle_count`=0.
- Reset overrides `start`, `branch` and halt in the same cycle.
- Fetch is single-cycle. `prog_ctr` is registered. `instr` and `branch` are combinational from it and are sampled at the next edge.
- Branch latency: with `branch`=1 sampled at edge N, `prog_ctr` equals the target after edge N.
- `running` and `done` are registered, decoded from the state register. They change on the same edge as the state.
- `done` rises on the edge that samples HALT in RUN.
- Restart from RUN (`start` reasserted mid-program): the next edge goes to ARMED, PC=0, and clears the count. No instruction completes on that edge.
- `start` held high continuously: remains in ARMED with PC=0 and no execution.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_state_t` enum (IDLE, ARMED, RUN, DONE).
  - `HALT_INSTR` constant.
  - `BRANCH_LUT` constant array of 2^LUT_AW PC_W-bit targets. This is the single place the assembler-generated table is edited.
- One sub-module, `branch_lut`: combinational index → target read of `BRANCH_LUT`.
- The PC, FSM and counter live in `fetch_unit` itself.

## Test plan
- **Reset**: assert `reset` 2 cycles with `start`=1, `branch`=1 → `prog_ctr`=0, `running`=0, `done`=0, `cycle_count`=0, state IDLE.
- **Sequential run**: pulse `start` 1 cycle, feed non-branch `instr`=`9'h000` for 5 cycles, then `9'h1FF` → `prog_ctr` steps 0,1,2,3,4,5 and holds at 5. `done`=1, `cycle_count`=6.
- **Branch**: `BRANCH_LUT[3]`=`10'h040`, `instr`=`9'h003` with `branch`=1 at PC=2 → next `prog_ctr`=`10'h040`. With `branch`=0 → next `prog_ctr`=3.
- **Halt vs branch**: `instr`=`9'h1FF` with `branch`=1 → PC holds, `done`=1, no jump to `BRANCH_LUT[31]`.
- **Restart mid-run**: assert `start` at PC=7 in RUN → next cycle ARMED, PC=0, `cycle_count`=0. Deassert → RUN resumes from 0. Relaunch from DONE behaves identically.
- **Wrap and saturation**: force a branch to PC=1023 then a non-branch → `prog_ctr`=0. With `CNT_W`=4, run 20 cycles → `cycle_count` stays at 15.
